// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI flash command sequencer and its Wishbone
// access engine: core register map, status/control bit positions, FSM
// encodings and common flash opcodes.
package spi_ctrl_pkg;

  // SPI core register addresses
  localparam logic [1:0] SPCR = 2'd0;
  localparam logic [1:0] SPSR = 2'd1;
  localparam logic [1:0] SPDR = 2'd2;
  localparam logic [1:0] SPER = 2'd3;

  // SPSR bit positions
  localparam int SPIF    = 7;
  localparam int WCOL    = 6;
  localparam int WFFULL  = 3;
  localparam int WFEMPTY = 2;
  localparam int RFFULL  = 1;
  localparam int RFEMPTY = 0;

  // SPCR bit positions
  localparam int SPIE = 7;
  localparam int SPE  = 6;
  localparam int SCS  = 5;

  // Flash opcodes
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDID = 8'h9F;

  typedef enum logic [3:0] {
    S_INIT_ER, S_INIT_CR, S_IDLE, S_CS_ON, S_TX,
    S_POLL, S_RX, S_OUT, S_CS_OFF, S_DONE
  } main_state_e;

  typedef enum logic [1:0] {A_IDLE, A_STB, A_WAIT} acc_state_e;

  // One register access for the engine
  typedef struct packed {
    logic       we;
    logic [1:0] adr;
    logic [7:0] wdata;
  } acc_req_t;

endpackage

// File: rtl/spi_wb_access.sv
// Single-access Wishbone engine: one-cycle strobe, then wait for ack with
// strobe low. The core pops its RX FIFO on every strobed data read, so the
// strobe must never last more than one cycle.
module spi_wb_access
  import spi_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  acc_req_t   req_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  acc_state_e state;

  // Strobe for one cycle, capture read data in the ack cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= A_IDLE;
      done_o  <= 1'b0;
      rdata_o <= '0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        A_IDLE: if (start_i) begin
          stb_o <= 1'b1;
          we_o  <= req_i.we;
          adr_o <= req_i.adr;
          if (req_i.we) dat_o <= req_i.wdata;
          state <= A_STB;
        end
        A_STB: begin
          stb_o <= 1'b0;
          if (ack_i) begin
            done_o  <= 1'b1;
            rdata_o <= dat_i;
            state   <= A_IDLE;
          end else begin
            state <= A_WAIT;
          end
        end
        A_WAIT: if (ack_i) begin
          done_o  <= 1'b1;
          rdata_o <= dat_i;
          state   <= A_IDLE;
        end
        default: state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_flash_ctrl.sv
// SPI flash command sequencer. Configures the Wishbone SPI core after reset,
// then runs CS-on / opcode / optional address / N reads / CS-off with exactly
// one byte in flight, streaming read bytes on a valid/ready port.
module spi_flash_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter logic [3:0] CLK_DIV   = 4'b0000,
  parameter logic       CPOL      = 1'b0,
  parameter logic       CPHA      = 1'b0,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_cmd_i,
  input  logic        req_has_addr_i,
  input  logic [23:0] req_addr_i,
  input  logic [15:0] req_len_i,
  output logic        rd_valid_o,
  output logic [7:0]  rd_data_o,
  input  logic        rd_ready_i,
  output logic        done_o,
  output logic        busy_o,
  output logic        spi_cyc_o,
  output logic        spi_stb_o,
  output logic        spi_we_o,
  output logic [1:0]  spi_adr_o,
  output logic [7:0]  spi_dat_o,
  input  logic [7:0]  spi_dat_i,
  input  logic        spi_ack_i
);

  // spcr with chip-select released (bit5=1) and with it asserted
  localparam logic [7:0] SPCR_CS_OFF = {1'b0, 1'b1, 1'b1, 1'b0, CPOL, CPHA, CLK_DIV[1:0]};
  localparam logic [7:0] SPCR_CS_ON  = SPCR_CS_OFF & ~(8'h01 << SCS);
  localparam logic [7:0] SPER_VAL    = {2'b00, 4'b0000, CLK_DIV[3:2]};

  main_state_e state;
  logic        pend;       // access issued for the current state, awaiting done
  logic        start;
  acc_req_t    acc_req;
  acc_req_t    acc_nxt;
  logic        acc_done;
  logic [7:0]  acc_rdata;
  logic        acc_stb;
  logic        is_acc;
  logic [2:0]  hdr_cnt;    // header bytes still to be clocked out
  logic [31:0] hdr_sr;     // opcode then address, MSB first
  logic [15:0] byte_cnt;

  assign req_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign spi_cyc_o   = acc_stb;
  assign spi_stb_o   = acc_stb;
  assign is_acc      = state inside {S_INIT_ER, S_INIT_CR, S_CS_ON, S_TX,
                                     S_POLL, S_RX, S_CS_OFF};

  // Register access requested by each bus-using state
  always_comb begin
    acc_nxt = '{we: 1'b1, adr: SPCR, wdata: SPCR_CS_OFF};
    case (state)
      S_INIT_ER: acc_nxt = '{we: 1'b1, adr: SPER, wdata: SPER_VAL};
      S_CS_ON:   acc_nxt = '{we: 1'b1, adr: SPCR, wdata: SPCR_CS_ON};
      S_TX:      acc_nxt = '{we: 1'b1, adr: SPDR,
                             wdata: (hdr_cnt != 3'd0) ? hdr_sr[31:24] : FILL_BYTE};
      S_POLL:    acc_nxt = '{we: 1'b0, adr: SPSR, wdata: 8'h00};
      S_RX:      acc_nxt = '{we: 1'b0, adr: SPDR, wdata: 8'h00};
      default:   ;
    endcase
  end

  // Main sequencer: one access per bus state, then advance on its done
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_INIT_ER;
      pend       <= 1'b0;
      start      <= 1'b0;
      acc_req    <= '0;
      hdr_cnt    <= '0;
      hdr_sr     <= '0;
      byte_cnt   <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      done_o     <= 1'b0;
    end else begin
      start <= 1'b0;
      if (is_acc) begin
        if (!pend) begin
          start   <= 1'b1;
          pend    <= 1'b1;
          acc_req <= acc_nxt;
        end else if (acc_done) begin
          pend <= 1'b0;
          case (state)
            S_INIT_ER: state <= S_INIT_CR;
            S_INIT_CR: state <= S_IDLE;
            S_CS_ON:   state <= S_TX;
            S_TX:      state <= S_POLL;
            S_POLL:    state <= acc_rdata[RFEMPTY] ? S_POLL : S_RX;
            S_RX: begin
              if (hdr_cnt != 3'd0) begin
                hdr_cnt <= hdr_cnt - 3'd1;
                hdr_sr  <= hdr_sr << 8;
                state   <= (hdr_cnt != 3'd1 || byte_cnt != 16'd0) ? S_TX : S_CS_OFF;
              end else begin
                rd_data_o  <= acc_rdata;
                rd_valid_o <= 1'b1;
                state      <= S_OUT;
              end
            end
            S_CS_OFF: begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end
            default: state <= S_INIT_ER;
          endcase
        end
      end else begin
        case (state)
          S_IDLE: if (req_valid_i) begin
            hdr_sr   <= {req_cmd_i, req_addr_i};
            hdr_cnt  <= req_has_addr_i ? 3'd4 : 3'd1;
            byte_cnt <= req_len_i;
            state    <= S_CS_ON;
          end
          S_OUT: if (rd_ready_i) begin
            rd_valid_o <= 1'b0;
            byte_cnt   <= byte_cnt - 16'd1;
            state      <= (byte_cnt != 16'd1) ? S_TX : S_CS_OFF;
          end
          S_DONE: begin
            done_o <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_INIT_ER;
        endcase
      end
    end
  end

  spi_wb_access u_acc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start),
    .req_i   (acc_req),
    .done_o  (acc_done),
    .rdata_o (acc_rdata),
    .stb_o   (acc_stb),
    .we_o    (spi_we_o),
    .adr_o   (spi_adr_o),
    .dat_o   (spi_dat_o),
    .dat_i   (spi_dat_i),
    .ack_i   (spi_ack_i)
  );

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Bench for spi_flash_ctrl: a behavioural SPI-core model (one-entry RX FIFO,
// random transfer latency) plus a transaction-level reference model of the
// expected MOSI stream, read data and chip-select writes.
module tb_spi_flash_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_has_addr;
  logic [7:0]  req_cmd;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic        rd_valid, rd_ready, done, busy;
  logic [7:0]  rd_data;
  logic        spi_cyc, spi_stb, spi_we, spi_ack;
  logic [1:0]  spi_adr;
  logic [7:0]  spi_wdat, spi_rdat;

  int passed = 0;
  int checks = 0;
  int viol_bus = 0;
  int viol_slv = 0;
  int done_cnt = 0;
  int nwr_dr = 0;

  logic [9:0] wr_log[$];   // {adr, data} of every write seen by the core
  logic [7:0] mosi_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] script[$];   // forced MISO replies, random when empty
  logic [7:0] rd_q[$];

  always #5 clk = ~clk;

  spi_flash_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
    .req_has_addr_i(req_has_addr), .req_addr_i(req_addr), .req_len_i(req_len),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_ready_i(rd_ready),
    .done_o(done), .busy_o(busy),
    .spi_cyc_o(spi_cyc), .spi_stb_o(spi_stb), .spi_we_o(spi_we),
    .spi_adr_o(spi_adr), .spi_dat_o(spi_wdat), .spi_dat_i(spi_rdat),
    .spi_ack_i(spi_ack)
  );

  function automatic logic [7:0] take_miso();
    logic [7:0] b;
    if (script.size() > 0) b = script.pop_front();
    else b = 8'($urandom);
    miso_q.push_back(b);
    return b;
  endfunction

  // SPI core model: registered ack, one-entry RX FIFO filled after a delay
  logic       rx_full, rx_pend, cs_n;
  logic [7:0] rx_byte, pend_byte;
  int         rx_delay;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_ack <= 1'b0; spi_rdat <= '0; rx_full <= 1'b0; rx_pend <= 1'b0;
      cs_n <= 1'b1; rx_byte <= '0; pend_byte <= '0; rx_delay <= 0;
    end else begin
      spi_ack <= 1'b0;
      if (rx_pend) begin
        if (rx_delay == 0) begin rx_full <= 1'b1; rx_byte <= pend_byte; rx_pend <= 1'b0; end
        else rx_delay <= rx_delay - 1;
      end
      if (spi_stb && !spi_ack) begin
        spi_ack <= 1'b1;
        if (spi_we) begin
          wr_log.push_back({spi_adr, spi_wdat});
          if (spi_adr == 2'd2) begin
            if (cs_n || rx_full || rx_pend) viol_slv <= viol_slv + 1;
            mosi_q.push_back(spi_wdat);
            pend_byte <= take_miso();
            rx_pend   <= 1'b1;
            rx_delay  <= $urandom_range(0, 5);
            nwr_dr    <= nwr_dr + 1;
          end
          if (spi_adr == 2'd0) cs_n <= spi_wdat[5];
        end else begin
          if (spi_adr == 2'd1) spi_rdat <= {7'b0, ~rx_full};
          else if (spi_adr == 2'd2) begin
            if (!rx_full) viol_slv <= viol_slv + 1;
            spi_rdat <= rx_byte;
            rx_full  <= 1'b0;
          end else spi_rdat <= 8'h00;
        end
      end
    end
  end

  // Bus-protocol monitor and read/done capture
  logic stb_d, done_d, outst;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_d <= 1'b0; done_d <= 1'b0; outst <= 1'b0;
    end else begin
      stb_d  <= spi_stb;
      done_d <= done;
      if ((spi_stb && stb_d) || (spi_cyc !== spi_stb) || (done && done_d) || (spi_stb && outst))
        viol_bus <= viol_bus + 1;
      if (spi_stb) outst <= 1'b1;
      else if (spi_ack) outst <= 1'b0;
      if (done) done_cnt <= done_cnt + 1;
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 3000 && req_ready !== 1'b1; i++) @(negedge clk);
    check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic check_init(input int w0);
    check("init_nwr", wr_log.size() - w0, 2);
    if (wr_log.size() >= w0 + 2) begin
      check("init_sper", {22'b0, wr_log[w0]},     {22'b0, 2'd3, 8'h00});
      check("init_spcr", {22'b0, wr_log[w0 + 1]}, {22'b0, 2'd0, 8'h60});
    end
  endtask

  task automatic send_req(input logic [7:0] cmd, input logic ha,
                          input logic [23:0] a, input logic [15:0] len);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_has_addr = ha; req_addr = a; req_len = len;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Run one transaction and compare against the transaction-level model
  task automatic run_txn(input logic [7:0] cmd, input logic ha, input logic [23:0] a,
                         input logic [15:0] len, input int stall);
    int m0, r0, w0, d0, hdr, n, i;
    logic [7:0] exp_mosi[$];
    logic [7:0] spcr_w[$];
    hdr = ha ? 4 : 1;
    exp_mosi.push_back(cmd);
    if (ha) begin
      exp_mosi.push_back(a[23:16]); exp_mosi.push_back(a[15:8]); exp_mosi.push_back(a[7:0]);
    end
    for (i = 0; i < int'(len); i++) exp_mosi.push_back(8'hFF);
    wait_ready();
    m0 = mosi_q.size(); r0 = rd_q.size(); w0 = wr_log.size(); d0 = done_cnt;
    if (stall > 0) rd_ready = 1'b0;
    send_req(cmd, ha, a, len);
    if (stall > 0) begin
      for (i = 0; i < 3000 && rd_valid !== 1'b1; i++) @(negedge clk);
      check("stall_rd_valid", {31'b0, rd_valid}, 32'd1);
      n = nwr_dr;
      repeat (stall) @(negedge clk);
      check("stall_no_dr_write", nwr_dr, n);
      check("stall_valid_held", {31'b0, rd_valid}, 32'd1);
      rd_ready = 1'b1;
    end
    for (i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("mosi_count", mosi_q.size() - m0, exp_mosi.size());
    for (i = 0; i < exp_mosi.size() && m0 + i < mosi_q.size(); i++)
      check("mosi_byte", {24'b0, mosi_q[m0 + i]}, {24'b0, exp_mosi[i]});
    check("rd_count", rd_q.size() - r0, int'(len));
    for (i = 0; i < int'(len) && r0 + i < rd_q.size() && m0 + hdr + i < miso_q.size(); i++)
      check("rd_byte", {24'b0, rd_q[r0 + i]}, {24'b0, miso_q[m0 + hdr + i]});
    for (i = w0; i < wr_log.size(); i++)
      if (wr_log[i][9:8] == 2'd0) spcr_w.push_back(wr_log[i][7:0]);
    check("spcr_writes", spcr_w.size(), 2);
    if (spcr_w.size() == 2) begin
      check("spcr_cs_on",  {24'b0, spcr_w[0]}, 32'h40);
      check("spcr_cs_off", {24'b0, spcr_w[1]}, 32'h60);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {8'b0, req_ready, rd_valid, rd_data, done, busy, spi_cyc, spi_stb,
            spi_we, spi_adr, spi_wdat};
  endfunction

  localparam logic [31:0] RESET_VEC = {8'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,
                                       1'b0, 1'b0, 2'b00, 8'h00};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, m0, w0, i, len;
    logic [7:0] cmd;
    rst = 1'b0; req_valid = 1'b0; req_cmd = '0; req_has_addr = 1'b0;
    req_addr = '0; req_len = '0; rd_ready = 1'b1;
    #1;
    check("reset_outputs", out_vec(), RESET_VEC);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Init sequence after reset release
    wait_ready();
    check_init(0);

    // RDID: fixed replies EF 40 18 after the opcode byte
    script.push_back(8'hA5); script.push_back(8'hEF);
    script.push_back(8'h40); script.push_back(8'h18);
    r0 = rd_q.size();
    run_txn(8'h9F, 1'b0, 24'h0, 16'd3, 0);
    if (rd_q.size() >= r0 + 3) begin
      check("rdid_0", {24'b0, rd_q[r0]},     32'hEF);
      check("rdid_1", {24'b0, rd_q[r0 + 1]}, 32'h40);
      check("rdid_2", {24'b0, rd_q[r0 + 2]}, 32'h18);
    end

    // READ with address, header discarded
    run_txn(8'h03, 1'b1, 24'h012345, 16'd2, 0);

    // WREN: opcode only, no read data
    run_txn(8'h06, 1'b0, 24'h0, 16'd0, 0);

    // Backpressure on the first read byte
    run_txn(8'h03, 1'b1, 24'hABCDEF, 16'd4, 50);

    // Randomized transactions, optionally with short stalls
    for (int k = 0; k < 6; k++) begin
      cmd = 8'($urandom);
      len = $urandom_range(0, 6);
      run_txn(cmd, 1'($urandom), 24'($urandom), 16'(len),
              (len > 0 && ($urandom % 2) == 1) ? int'($urandom_range(1, 20)) : 0);
    end

    // Asynchronous reset during the address phase
    wait_ready();
    m0 = mosi_q.size();
    send_req(8'h03, 1'b1, 24'h00F00D, 16'd4);
    for (i = 0; i < 3000 && mosi_q.size() < m0 + 2; i++) @(negedge clk);
    check("abort_reached_addr", {31'b0, mosi_q.size() >= m0 + 2}, 32'd1);
    #2 rst = 1'b0;
    #1 check("abort_reset_outputs", out_vec(), RESET_VEC);
    @(negedge clk);
    w0 = wr_log.size();
    rst = 1'b1;
    wait_ready();
    check_init(w0);
    run_txn(8'h03, 1'b1, 24'h00F00D, 16'd3, 0);

    check("bus_protocol_violations", viol_bus, 0);
    check("core_model_violations", viol_slv, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_ctrl.md
Name: spi_flash_ctrl

Overview:
Command sequencer that drives the 8-bit Wishbone SPI master core as its only bus master. It configures the core once after reset, then executes SPI-flash style transactions: chip-select assert, opcode, optional 24-bit address, N read bytes, chip-select release. Read bytes stream out on a valid/ready port. It sits between the boot/loader logic and the SPI core, replacing software register polling.

Parameters:
CLK_DIV, 4'b0000, {spre,spr} clock-rate select written to the core (0000 = clk_i/2)
CPOL, 1'b0, SPI clock polarity written to spcr[3]
CPHA, 1'b0, SPI clock phase written to spcr[2]
FILL_BYTE, 8'hFF, MOSI byte sent during the read phase

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  transaction request
req_ready_o  out  1  high in IDLE only
req_cmd_i  in  8  opcode byte
req_has_addr_i  in  1  send 3 address bytes after the opcode
req_addr_i  in  24  address, MSB first
req_len_i  in  16  read bytes after the header (0 = header only)
rd_valid_o  out  1  read byte available
rd_data_o  out  8  read byte
rd_ready_i  in  1  consumer accepts rd_data_o
done_o  out  1  one-cycle pulse after chip-select release
busy_o  out  1  high outside IDLE
spi_cyc_o, spi_stb_o  out  1  Wishbone strobe to the core (always equal)
spi_we_o  out  1  write enable
spi_adr_o  out  2  0=spcr 1=spsr 2=data 3=sper
spi_dat_o  out  8  write data
spi_dat_i  in  8  read data (core dat_o[7:0])
spi_ack_i  in  1  core ack

Behaviour:
- Reset values: all outputs 0 except state = INIT_ER; req_ready_o=0, busy_o=1 until IDLE.
- Bus rule: every access drives cyc/stb high for exactly one cycle, then waits with stb low until spi_ack_i. spi_dat_i is sampled in the ack cycle. This is mandatory because the core pops its RX FIFO on every strobed data-read cycle; a two-cycle strobe loses a byte. Only one access is outstanding at a time.
- Access engine states: A_IDLE -> A_STB (1 cycle) -> A_WAIT (until ack) -> A_IDLE, with a done pulse to the main FSM.
- Main FSM:
  - INIT_ER: write sper = {2'b00,4'b0000,CLK_DIV[3:2]}.
  - INIT_CR: write spcr = {0,1,1,0,CPOL,CPHA,CLK_DIV[1:0]}; this sets spe=1 and CS deasserted (spcr[5]=1).
  - IDLE: req_ready_o=1. On req_valid_i, latch the request. hdr_cnt = has_addr ? 4 : 1; byte_cnt = len.
  - CS_ON: write spcr with bit5=0.
  - TX: write the data register. The byte sent is the opcode, then addr[23:16], addr[15:8], addr[7:0] while hdr_cnt>0; after that it is FILL_BYTE.
  - POLL: read spsr. If bit0 (rfempty)=1, repeat POLL; otherwise go to RX.
  - RX: read the data register.
    - During the header, decrement hdr_cnt and discard the byte.
    - During the read phase, hold the byte in OUT.
  - OUT: rd_valid_o=1 until rd_ready_i. On accept, decrement byte_cnt. No new TX is issued while the byte is unaccepted.
  - Next: TX if hdr_cnt>0 or byte_cnt>0; else CS_OFF.
  - CS_OFF: write spcr with bit5=1.
  - DONE: done_o=1 for 1 cycle, then IDLE.
- Exactly one byte is in flight; the core's FIFO never holds more than one entry.
- len=0 with has_addr=0: opcode only (e.g. 0x06 write-enable).
- len=65535 is supported; byte_cnt is 16-bit with no wrap.
- req_valid_i outside IDLE is ignored; the request is not queued.
- Asynchronous reset mid-transaction: restart at INIT_ER. Chip-select is restored by INIT_CR rewriting spcr. A pending rd byte is dropped.
- spi_dat_o holds its value between accesses; spi_we_o is only meaningful with stb.

Decomposition:
- Package spi_ctrl_pkg holds:
  - register addresses SPCR=0, SPSR=1, SPDR=2, SPER=3
  - SPSR bit indices SPIF=7, WCOL=6, WFFULL=3, WFEMPTY=2, RFFULL=1, RFEMPTY=0
  - SPCR bit indices SPIE=7, SPE=6, SCS=5
  - main and access FSM state encodings
  - flash opcodes READ=8'h03, RDSR=8'h05, WREN=8'h06, RDID=8'h9F
- Sub-module: spi_wb_access, the single-access Wishbone engine (start, we, adr, wdata -> done, rdata).

Test Plan:
1. Reset release -> exactly two writes seen: adr3=8'h00, then adr0=8'h60 (CPOL=CPHA=0, CLK_DIV=0); then req_ready_o=1.
2. Command cmd=8'h9F, has_addr=0, len=3, slave model returns EF 40 18 -> MOSI bytes 9F FF FF FF; rd_data 8'hEF, 8'h40, 8'h18; spcr writes 8'h40 then 8'h60; done_o single pulse.
3. Command cmd=8'h03, addr=24'h012345, len=2 -> MOSI 03 01 23 45 FF FF; exactly 2 rd_valid handshakes; 4 header bytes discarded.
4. Command cmd=8'h06, len=0 -> one data write of 8'h06, CS low for that byte only, no rd_valid_o.
5. Backpressure with rd_ready_i low for 50 cycles on the first byte -> no data-register write occurs during the stall; all bytes arrive in order.
6. Assert rst_i low during the address phase -> all outputs return to reset values asynchronously; the INIT sequence re-runs; the next request completes correctly.
